// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, plus the
//   MTHI/MTLO moves. Owns the architectural HI/LO registers.
//
//   Multiply: radix-2 shift-add over operand magnitudes, one bit per cycle.
//   Divide  : restoring shift-subtract over magnitudes, one bit per cycle.
//   Signs are applied in a single FIX cycle after Data_Width iterations.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op         request qualified by op (0 MULT, 1 MULTU, 2 DIV,
//                     3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op); IDLE only
//   flush             aborts an in-flight mul/div, HI/LO untouched
//   data_in1/2        rs / rt operands
//   busy              high while a mul/div is in flight (CALC or FIX)
//   done              one-cycle pulse when a new mul/div result lands
//   hi, lo            HI / LO registers
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  flush,
    input  logic [Data_Width-1:0] data_in1,
    input  logic [Data_Width-1:0] data_in2,
    output logic                  busy,
    output logic                  done,
    output logic [Data_Width-1:0] hi,
    output logic [Data_Width-1:0] lo
);

    localparam int W  = Data_Width;
    localparam int CW = $clog2(Data_Width);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]    opnd_q, opnd_d;     // mul: multiplicand magnitude; div: divisor magnitude
    logic            is_div_q, is_div_d;
    logic            neg_lo_q, neg_lo_d; // product / quotient sign
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;

    // Request decode (only meaningful in IDLE)
    logic            idle;
    logic            req_md;
    logic            req_mt;
    logic            signed_op;
    logic            s1, s2;
    logic [W-1:0]    mag1, mag2;

    // Iteration datapath
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [2*W-1:0]  div_next;

    // FIX-cycle results
    logic [2*W-1:0]  mul_res;
    logic [W-1:0]    quo_res;
    logic [W-1:0]    rem_res;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_md) state_d = S_CALC;
            S_CALC: begin
                if (flush)                        state_d = S_IDLE;
                else if (cnt_q == CW'(W - 1))     state_d = S_FIX;
            end
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // -----------------------------------------------------------------------
    // Request decode and operand magnitudes
    // -----------------------------------------------------------------------
    always_comb begin
        idle      = (state_q == S_IDLE);
        req_md    = idle && start && !op[2];
        req_mt    = idle && start && (op == 3'd4 || op == 3'd5);
        signed_op = !op[0];                  // MULT and DIV are the even codes
        s1        = signed_op && data_in1[W-1];
        s2        = signed_op && data_in2[W-1];
        // The most negative value negates to itself, which read as unsigned
        // is exactly 2^(W-1) -- the correct magnitude.
        mag1      = s1 ? (~data_in1 + W'(1)) : data_in1;
        mag2      = s2 ? (~data_in2 + W'(1)) : data_in2;
    end

    // -----------------------------------------------------------------------
    // One iteration of each algorithm
    // -----------------------------------------------------------------------
    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit (LSB) is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc_q[W-1:1]};

        // Restoring divide: bring the next dividend bit into the remainder,
        // subtract if it fits. The remainder stays below the divisor, so the
        // difference always fits back into W bits.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_next  = div_ge ? {div_diff[W-1:0],  acc_q[W-2:0], 1'b1}
                           : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end

    // -----------------------------------------------------------------------
    // Sign fix-up. Divide-by-zero leaves the remainder equal to the dividend
    // magnitude, so applying the dividend sign reproduces data_in1 as given;
    // only the quotient needs forcing to all ones.
    // -----------------------------------------------------------------------
    always_comb begin
        mul_res = neg_lo_q  ? (~acc_q + (2*W)'(1)) : acc_q;
        rem_res = neg_rem_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
        if (div0_q)        quo_res = '1;
        else if (neg_lo_q) quo_res = ~acc_q[W-1:0] + W'(1);
        else               quo_res = acc_q[W-1:0];
    end

    // -----------------------------------------------------------------------
    // Datapath register updates
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_md) begin
                    is_div_d  = op[1];
                    neg_lo_d  = s1 ^ s2;
                    neg_rem_d = s1;
                    div0_d    = op[1] && (data_in2 == '0);
                    cnt_d     = '0;
                    if (op[1]) begin
                        acc_d  = {{W{1'b0}}, mag1};
                        opnd_d = mag2;
                    end else begin
                        acc_d  = {{W{1'b0}}, mag2};
                        opnd_d = mag1;
                    end
                end else if (req_mt) begin
                    if (op[0]) lo_d = data_in1;
                    else       hi_d = data_in1;
                end
            end
            S_CALC: begin
                if (!flush) begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[2*W-1:W];
                        lo_d = mul_res[W-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic          flush;
    logic [W-1:0]  data_in1, data_in2;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int ncmp  = 0;
    int nfail = 0;

    // Reference architectural state
    logic [W-1:0] m_hi, m_lo;

    mips_muldiv_unit #(.Data_Width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .flush    (flush),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: MIPS semantics with plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sp, sq, sr;
        logic [63:0] up;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd1: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_hi = 0; m_lo = 32'h8000_0000;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    up = sq; m_lo = up[31:0];
                    up = sr; m_hi = up[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op from IDLE and check timing plus result against the model.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int early;
        @(negedge clk);
        start = 1'b1; op = o; data_in1 = a; data_in2 = b;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        model(o, a, b);
        if (o <= 3'd3) begin
            n = 0; early = 0;
            while (busy === 1'b1 && n < 100) begin
                if (done !== 1'b0) early++;
                n++;
                @(negedge clk);
            end
            check("busy_len", 64'(n), 64'(W + 1));
            check("done_early", 64'(early), 64'd0);
            check("done_pulse", 64'(done), 64'd1);
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            @(negedge clk);
            check("done_clr", 64'(done), 64'd0);
        end else begin
            check("mt_busy", 64'(busy), 64'd0);
            check("mt_done", 64'(done), 64'd0);
            check("mt_hi", 64'(hi), 64'(m_hi));
            check("mt_lo", 64'(lo), 64'(m_lo));
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 15));
            4: v = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            5: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int dn;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 3'd6; flush = 1'b0;
        data_in1 = '0; data_in2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // Directed vectors with literal expectations
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF); check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE); check("multu_lo", 64'(lo), 64'h1);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
        check("mmin_hi", 64'(hi), 64'h4000_0000); check("mmin_lo", 64'(lo), 64'h0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF); check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2);
        check("divu_hi", 64'(hi), 64'd1); check("divu_lo", 64'(lo), 64'd3);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_hi", 64'(hi), 64'd0); check("ovf_lo", 64'(lo), 64'h8000_0000);
        run_op(3'd3, 32'd5, 32'd0);
        check("dz_u_hi", 64'(hi), 64'd5); check("dz_u_lo", 64'(lo), 64'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF7, 32'd0);
        check("dz_s_hi", 64'(hi), 64'hFFFF_FFF7); check("dz_s_lo", 64'(lo), 64'hFFFF_FFFF);

        // MTHI then MTLO on back-to-back cycles
        @(negedge clk);
        start = 1'b1; op = 3'd4; data_in1 = 32'h1234;
        @(negedge clk);
        check("mthi_busy", 64'(busy), 64'd0);
        op = 3'd5; data_in1 = 32'hABCD;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mt_hi2", 64'(hi), 64'h1234); check("mt_lo2", 64'(lo), 64'hABCD);
        m_hi = 32'h1234; m_lo = 32'hABCD;

        // Requests while busy are dropped, including MTHI
        @(negedge clk);
        start = 1'b1; op = 3'd0; data_in1 = 32'd3; data_in2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd2; data_in1 = 32'd100; data_in2 = 32'd7;
        @(negedge clk);
        op = 3'd4; data_in1 = 32'd55;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        check("bz_done", 64'(done), 64'd1);
        check("bz_hi", 64'(hi), 64'd0); check("bz_lo", 64'(lo), 64'd12);
        @(negedge clk);
        check("bz_idle", 64'(busy), 64'd0);
        m_hi = 0; m_lo = 12;

        // Flush mid-MULT; a start in the same cycle is ignored
        run_op(3'd4, 32'h1111_0000, 32'd0);
        run_op(3'd5, 32'h0000_2222, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; data_in1 = 32'd5; data_in2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd5; data_in1 = 32'd777;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; op = 3'd6;
        check("fl_busy", 64'(busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dn++;
            @(negedge clk);
        end
        check("fl_nodone", 64'(dn), 64'd0);
        check("fl_hi", 64'(hi), 64'h1111_0000); check("fl_lo", 64'(lo), 64'h2222);

        // Flush in IDLE does not block an MTHI
        flush = 1'b1; start = 1'b1; op = 3'd4; data_in1 = 32'hBEEF;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; op = 3'd6;
        check("fli_hi", 64'(hi), 64'hBEEF); check("fli_busy", 64'(busy), 64'd0);
        m_hi = 32'hBEEF;

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd2; data_in1 = 32'd1000; data_in2 = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_hi", 64'(hi), 64'd0); check("ar_lo", 64'(lo), 64'd0);
        check("ar_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = 0; m_lo = 0;

        // Randomized ops against the model
        for (int k = 0; k < 1500; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
